// File: rtl/sweep_pkg.sv
// Shared FSM state encoding for the sweep sequencer, its ILA decode and the control block.
package sweep_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 3'd0,
      S_CFG   = 3'd1,
      S_LOCK  = 3'd2,
      S_CLR   = 3'd3,
      S_RUN   = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Counters are loaded with count-1, so clog2(count) bits always suffice.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter shared by the CLR, RUN and lock-timeout phases; saturates at zero.
module sweep_timer #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// Steps the MMCM through NUM_STEPS settings, runs the DUT and drains its FIFO into BRAM per step.
// Optional lock timeout (ERR state) is enabled by defining SWEEP_TIMEOUT_EN.
module sweep_sequencer
   import sweep_pkg::*;
#(
   parameter int AddrWL     = 9,
   parameter int StepWL     = 4,
   parameter int NUM_STEPS  = 16,
   parameter int RUN_CYCLES = 256,
   parameter int CLR_CYCLES = 8,
   parameter int LOCK_TMO   = 65535
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   output logic                cfg_req,
   output logic [StepWL-1:0]   cfg_step,
   input  logic                cfg_ack,
   input  logic                mmcm_lock,
   output logic                dut_en,
   output logic                fifo_clear,
   input  logic                fifo_empty,
   output logic                fifo_rd_en,
   output logic                bram_we,
   output logic [AddrWL-1:0]   bram_waddr,
   output logic [StepWL-1:0]   step_idx,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                ovf,
   output logic [STATE_W-1:0]  state
);

   localparam int TMAX = max3(RUN_CYCLES, CLR_CYCLES, LOCK_TMO);
   localparam int TW   = cnt_width(TMAX);
   localparam logic [AddrWL-1:0] ADDR_MAX  = '1;
   localparam logic [StepWL-1:0] STEP_LAST = StepWL'(NUM_STEPS - 1);

   state_e              state_q, state_d;
   logic [StepWL-1:0]   step_q, step_d;
   logic [AddrWL-1:0]   waddr_q, waddr_d;
   logic                full_q, full_d;
   logic                ovf_q, ovf_d;
   logic                rd_en_q, rd_en_d;
   logic                we_q, we_d;
   logic                cfg_req_q, cfg_req_d;
   logic                dut_en_q, dut_en_d;
   logic                fifo_clear_q, fifo_clear_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef SWEEP_TIMEOUT_EN
   logic                err_q, err_d;
`endif

   logic                take_start;
   logic                tmr_load;
   logic [TW-1:0]       tmr_val;
   logic                tmr_zero;

   sweep_timer #(.W(TW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_val),
      .zero  (tmr_zero)
   );

   assign take_start = start && !abort;

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      waddr_d  = waddr_q;
      full_d   = full_q;
      ovf_d    = ovf_q;
      rd_en_d  = 1'b0;
      we_d     = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;

      // The address advances after each completed write and sticks at the top entry.
      if (we_q) begin
         if (waddr_q == ADDR_MAX) begin
            full_d = 1'b1;
         end else begin
            waddr_d = waddr_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (take_start) begin
               state_d = S_CFG;
               step_d  = '0;
               waddr_d = '0;
               full_d  = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         S_CFG: begin
            tmr_load = 1'b1;
            tmr_val  = TW'(LOCK_TMO - 1);
            if (cfg_ack) begin
               state_d = S_LOCK;
            end
         end
         S_LOCK: begin
            if (mmcm_lock) begin
               state_d  = S_CLR;
               tmr_load = 1'b1;
               tmr_val  = TW'(CLR_CYCLES - 1);
            end
`ifdef SWEEP_TIMEOUT_EN
            else if (tmr_zero) begin
               state_d = S_ERR;
            end
`endif
         end
         S_CLR: begin
            if (tmr_zero) begin
               state_d  = S_RUN;
               tmr_load = 1'b1;
               tmr_val  = TW'(RUN_CYCLES - 1);
            end
         end
         S_RUN: begin
            if (tmr_zero) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (rd_en_q) begin
               if (full_d) begin
                  ovf_d = 1'b1;
               end else begin
                  we_d = 1'b1;
               end
            end
            // fifo_empty only reflects a read one cycle after it, so reads are issued
            // on alternate cycles to avoid striking an already-empty FIFO.
            if (!rd_en_q) begin
               if (fifo_empty) begin
                  if (step_q == STEP_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_CFG;
                     step_d  = step_q + 1'b1;
                  end
               end else begin
                  rd_en_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         rd_en_d = 1'b0;
         we_d    = 1'b0;
      end

      cfg_req_d    = (state_d == S_CFG);
      dut_en_d     = (state_d == S_RUN);
      fifo_clear_d = (state_d == S_CLR);
      done_d       = (state_d == S_DONE);
      busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
`ifdef SWEEP_TIMEOUT_EN
      err_d        = (state_d == S_ERR);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         step_q       <= '0;
         waddr_q      <= '0;
         full_q       <= 1'b0;
         ovf_q        <= 1'b0;
         rd_en_q      <= 1'b0;
         we_q         <= 1'b0;
         cfg_req_q    <= 1'b0;
         dut_en_q     <= 1'b0;
         fifo_clear_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         waddr_q      <= waddr_d;
         full_q       <= full_d;
         ovf_q        <= ovf_d;
         rd_en_q      <= rd_en_d;
         we_q         <= we_d;
         cfg_req_q    <= cfg_req_d;
         dut_en_q     <= dut_en_d;
         fifo_clear_q <= fifo_clear_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef SWEEP_TIMEOUT_EN
         err_q        <= err_d;
`endif
      end
   end

   assign cfg_req    = cfg_req_q;
   assign cfg_step   = step_q;
   assign dut_en     = dut_en_q;
   assign fifo_clear = fifo_clear_q;
   assign fifo_rd_en = rd_en_q;
   assign bram_we    = we_q;
   assign bram_waddr = waddr_q;
   assign step_idx   = step_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign ovf        = ovf_q;
   assign state      = state_q;
`ifdef SWEEP_TIMEOUT_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer: DRP/lock and FIFO models drive the DUT, a monitor
// checks writes, cfg steps and run windows against queued expectations.
`timescale 1ns/1ps
module tb_sweep_sequencer;
   import sweep_pkg::*;

   localparam int AW = 3;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst, start, abort;
   logic          cfg_req, cfg_ack, mmcm_lock;
   logic [SW-1:0] cfg_step, step_idx;
   logic          dut_en, fifo_clear, fifo_empty, fifo_rd_en, bram_we;
   logic [AW-1:0] bram_waddr;
   logic          busy, done, err, ovf;
   logic [2:0]    state;

   int checks   = 0;
   int failures = 0;
   int exp_addr[$];
   int exp_cfg[$];
   int exp_run[$];

   int per_step      = 3;
   bit lock_hold_low = 1'b0;
   int fifo_words    = 0;

   bit m_req_prev = 1'b0, m_acked = 1'b0, m_rd_prev = 1'b0, m_en_prev = 1'b0;
   int m_req_age  = 0, m_lock_age = 0;

   bit mon_rd_prev = 1'b0, mon_cfg_prev = 1'b0;
   int mon_run_len = 0;

   always #2.5 clk = ~clk;

   sweep_sequencer #(
      .AddrWL(AW), .StepWL(SW), .NUM_STEPS(2),
      .RUN_CYCLES(4), .CLR_CYCLES(2), .LOCK_TMO(10)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_req(cfg_req), .cfg_step(cfg_step), .cfg_ack(cfg_ack), .mmcm_lock(mmcm_lock),
      .dut_en(dut_en), .fifo_clear(fifo_clear), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .bram_we(bram_we), .bram_waddr(bram_waddr),
      .step_idx(step_idx), .busy(busy), .done(done), .err(err), .ovf(ovf), .state(state)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Environment: DRP acks 3 cycles after cfg_req rises, lock follows 5 cycles after ack;
   // the FIFO receives per_step words when dut_en falls and pops on each fifo_rd_en.
   initial begin : env_model
      cfg_ack    = 1'b0;
      mmcm_lock  = 1'b0;
      fifo_empty = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (m_rd_prev && fifo_words > 0) fifo_words--;
         if (m_en_prev && !dut_en) fifo_words += per_step;
         if (fifo_clear) fifo_words = 0;
         fifo_empty = (fifo_words == 0);
         m_rd_prev  = fifo_rd_en;
         m_en_prev  = dut_en;
         cfg_ack    = 1'b0;
         if (cfg_req && !m_req_prev) begin
            m_req_age  = 0;
            m_acked    = 1'b0;
            m_lock_age = 0;
            mmcm_lock  = 1'b0;
         end else if (cfg_req) begin
            m_req_age++;
         end
         if (cfg_req && m_req_age == 3 && !m_acked) begin
            cfg_ack = 1'b1;
            m_acked = 1'b1;
         end else if (m_acked && !mmcm_lock && !lock_hold_low) begin
            m_lock_age++;
            if (m_lock_age == 5) mmcm_lock = 1'b1;
         end
         m_req_prev = cfg_req;
      end
   end

   initial begin : monitor
      int e;
      forever begin
         @(negedge clk);
         if (bram_we) begin
            $display("tb: write addr=%0d", bram_waddr);
            check("we_follows_rd", int'(mon_rd_prev), 1);
            if (exp_addr.size() == 0) begin
               check("unexpected_write_addr", int'(bram_waddr), -1);
            end else begin
               e = exp_addr.pop_front();
               check("bram_waddr", int'(bram_waddr), e);
            end
         end
         mon_rd_prev = fifo_rd_en;
         if (cfg_req && !mon_cfg_prev) begin
            $display("tb: cfg_req step=%0d", cfg_step);
            if (exp_cfg.size() == 0) begin
               check("unexpected_cfg_step", int'(cfg_step), -1);
            end else begin
               e = exp_cfg.pop_front();
               check("cfg_step", int'(cfg_step), e);
            end
         end
         mon_cfg_prev = cfg_req;
         if (dut_en) begin
            mon_run_len++;
         end else if (mon_run_len != 0) begin
            $display("tb: run window cycles=%0d", mon_run_len);
            if (exp_run.size() == 0) begin
               check("unexpected_run_window", mon_run_len, -1);
            end else begin
               e = exp_run.pop_front();
               check("dut_en_cycles", mon_run_len, e);
            end
            mon_run_len = 0;
         end
      end
   end

   task automatic push_sweep(input int n_writes);
      exp_cfg.push_back(0);
      exp_cfg.push_back(1);
      exp_run.push_back(4);
      exp_run.push_back(4);
      for (int i = 0; i < n_writes; i++) exp_addr.push_back(i);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s, input int bound, input string name);
      int n = 0;
      while (state != s && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (state != s) check({"timeout_", name}, int'(state), int'(s));
   endtask

   initial begin : watchdog
      #200us;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_state", int'(state), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_ovf", int'(ovf), 0);
      check("rst_waddr", int'(bram_waddr), 0);
      check("rst_step", int'(step_idx), 0);
      check("rst_strobes", int'({cfg_req, dut_en, fifo_clear, fifo_rd_en, bram_we}), 0);

      // Two-step sweep, 3 words per step.
      per_step = 3;
      push_sweep(6);
      pulse_start();
      check("t1_start_state", int'(state), int'(S_CFG));
      check("t1_cfg_req", int'(cfg_req), 1);
      check("t1_busy", int'(busy), 1);
      wait_state(S_DONE, 3000, "t1_done");
      check("t1_done", int'(done), 1);
      check("t1_busy_done", int'(busy), 0);
      check("t2_waddr_done", int'(bram_waddr), 6);
      check("t2_ovf", int'(ovf), 0);
      check("t1_step_last", int'(step_idx), 1);

      // BRAM overflow: 12 words into 8 entries.
      per_step = 6;
      push_sweep(8);
      pulse_start();
      wait_state(S_DONE, 3000, "t3_done");
      check("t3_done", int'(done), 1);
      check("t3_ovf", int'(ovf), 1);
      check("t3_waddr", int'(bram_waddr), 7);
      check("t3_fifo_drained", fifo_words, 0);

      // Abort in the second RUN cycle, then a fresh sweep.
      per_step = 3;
      exp_cfg.push_back(0);
      exp_run.push_back(2);
      pulse_start();
      check("t4_ovf_cleared", int'(ovf), 0);
      wait_state(S_RUN, 200, "t4_run");
      @(posedge clk); #1;
      pulse_abort();
      check("t4_abort_state", int'(state), int'(S_IDLE));
      check("t4_abort_dut_en", int'(dut_en), 0);
      check("t4_abort_busy", int'(busy), 0);
      repeat (5) @(posedge clk);
      push_sweep(6);
      pulse_start();
      check("t4_restart_state", int'(state), int'(S_CFG));
      check("t4_restart_step", int'(step_idx), 0);
      wait_state(S_DONE, 3000, "t4_done");
      check("t4_waddr", int'(bram_waddr), 6);

      // Lock never arrives.
      lock_hold_low = 1'b1;
      exp_cfg.push_back(0);
      pulse_start();
      wait_state(S_LOCK, 200, "t5_lock");
`ifdef SWEEP_TIMEOUT_EN
      n = 0;
      while (state == S_LOCK && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t5_lock_cycles", n, 10);
      check("t5_err_state", int'(state), int'(S_ERR));
      check("t5_err", int'(err), 1);
      check("t5_busy", int'(busy), 0);
      check("t5_strobes", int'({cfg_req, dut_en, fifo_clear, fifo_rd_en, bram_we}), 0);
      lock_hold_low = 1'b0;
      exp_cfg.push_back(0);
      pulse_start();
      check("t5_restart_state", int'(state), int'(S_CFG));
      check("t5_restart_step", int'(step_idx), 0);
      check("t5_err_cleared", int'(err), 0);
      pulse_abort();
`else
      repeat (1000) @(negedge clk);
      check("t5_still_lock", int'(state), int'(S_LOCK));
      check("t5_err_tied", int'(err), 0);
      check("t5_busy", int'(busy), 1);
      lock_hold_low = 1'b0;
      #1 pulse_abort();
`endif
      check("t5_idle", int'(state), int'(S_IDLE));

      // start ignored in DRAIN, then rst mid-drain.
      per_step = 3;
      exp_cfg.push_back(0);
      exp_run.push_back(4);
      exp_addr.push_back(0);
      pulse_start();
      wait_state(S_DRAIN, 300, "t6_drain");
      @(posedge clk); #1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("t6_start_ignored_state", int'(state), int'(S_DRAIN));
      check("t6_start_ignored_waddr", int'(bram_waddr), 1);
      check("t6_rd_en", int'(fifo_rd_en), 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("t6_rst_state", int'(state), 0);
      check("t6_rst_outputs", int'({cfg_req, dut_en, fifo_clear, fifo_rd_en, bram_we,
                                    busy, done, err, ovf}), 0);
      check("t6_rst_waddr", int'(bram_waddr), 0);
      check("t6_rst_step", int'(step_idx), 0);

      repeat (5) @(negedge clk);
      check("pending_writes", exp_addr.size(), 0);
      check("pending_cfg", exp_cfg.size(), 0);
      check("pending_runs", exp_run.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
